// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for demux_router (optional DEMUX_ROUTER_ERRCNT_EN)
package demux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NCH   = 4;

  // Discard counter is a fixed 8-bit saturating counter
  localparam int ERR_CNT_W = 8;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;
  localparam err_cnt_t ERR_CNT_MAX = 8'd255;

  // Increment that sticks at ERR_CNT_MAX instead of wrapping back to zero
  function automatic err_cnt_t sat_inc(input err_cnt_t v);
    return (v == ERR_CNT_MAX) ? v : v + err_cnt_t'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output buffer (full flag plus data register) for demux_router
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  // Occupancy: a load wins over a pop so a same-cycle pop plus refill stays full
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // Data only moves on load, so the last word lingers after the slot drains
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/demux_router.sv
// rtl/demux_router.sv - 1-to-NCH demultiplexer with per-channel one-entry slots (optional DEMUX_ROUTER_ERRCNT_EN)
module demux_router
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NCH   = DEFAULT_NCH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(NCH)-1:0]   in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NCH*WIDTH-1:0]     out_data,
  output logic [NCH-1:0]           out_valid,
  input  logic [NCH-1:0]           out_ready
`ifdef DEMUX_ROUTER_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0]     err_cnt
`endif
);

  localparam int SEL_W = $clog2(NCH);
  // Channel count widened by one bit so the range test works for any NCH
  localparam logic [SEL_W:0] NCH_V = (SEL_W + 1)'(NCH);

  logic           sel_in_range;
  logic [NCH-1:0] sel_hit;
  logic [NCH-1:0] full;
  logic [NCH-1:0] load;
  logic [NCH-1:0] pop;
  logic           sel_ready;
  logic           in_fire;

  assign sel_in_range = ({1'b0, in_sel} < NCH_V);

  // One-hot decode of the destination; all-zero for an out-of-range select
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      sel_hit[i] = sel_in_range && (in_sel == SEL_W'(i));
    end
  end

  // The addressed slot can take a word if empty or being drained this cycle.
  // Out-of-range words are always taken (and dropped) so they never block.
  assign sel_ready = |(sel_hit & (~full | out_ready));
  assign in_ready  = !rst && (!sel_in_range || sel_ready);
  assign in_fire   = in_valid && in_ready;

  assign load      = {NCH{in_fire}} & sel_hit;
  assign pop       = full & out_ready;
  assign out_valid = full;

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[g]),
      .load_data(in_data),
      .pop      (pop[g]),
      .full     (full[g]),
      .data     (out_data[g*WIDTH +: WIDTH])
    );
  end

`ifdef DEMUX_ROUTER_ERRCNT_EN
  logic discard;
  assign discard = in_fire && !sel_in_range;

  // Saturating count of accepted-and-dropped out-of-range words
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (discard) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_demux_router.sv
// tb/tb_demux_router.sv - self-checking bench for demux_router (covers DEMUX_ROUTER_ERRCNT_EN when defined)
`timescale 1ns/1ps
module tb_demux_router;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int NCH5  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, NCH=4
  logic                 rst;
  logic [WIDTH-1:0]     in_data;
  logic [1:0]           in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;

  // Second instance, NCH=5, for out-of-range selects
  logic                  rst5;
  logic [WIDTH-1:0]      in_data5;
  logic [2:0]            in_sel5;
  logic                  in_valid5;
  logic                  in_ready5;
  logic [NCH5*WIDTH-1:0] out_data5;
  logic [NCH5-1:0]       out_valid5;
  logic [NCH5-1:0]       out_ready5;

`ifdef DEMUX_ROUTER_ERRCNT_EN
  logic [7:0] err_cnt;
  logic [7:0] err_cnt5;
`endif

  demux_router #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef DEMUX_ROUTER_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  demux_router #(.WIDTH(WIDTH), .NCH(NCH5)) dut5 (
    .clk(clk), .rst(rst5), .in_data(in_data5), .in_sel(in_sel5),
    .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
    .out_valid(out_valid5), .out_ready(out_ready5)
`ifdef DEMUX_ROUTER_ERRCNT_EN
    , .err_cnt(err_cnt5)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference: words accepted for each channel and not yet consumed, oldest first
  logic [WIDTH-1:0] q [NCH][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A channel takes a word when it holds nothing or its consumer takes the held word now
  function automatic logic exp_ready();
    if (rst) return 1'b0;
    return (q[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  // Called at a falling edge with inputs already driven: check, advance the reference, move to next falling edge
  task automatic step(input string tag);
    logic           er;
    logic [NCH-1:0] ev;
    #1;
    er = exp_ready();
    for (int i = 0; i < NCH; i++) ev[i] = (q[i].size() != 0);
    check({tag, ".in_ready"}, in_ready, er);
    check({tag, ".out_valid"}, out_valid, ev);
    for (int i = 0; i < NCH; i++)
      if (ev[i]) check($sformatf("%s.data%0d", tag, i), out_data[i*WIDTH +: WIDTH], q[i][0]);
    if (rst) begin
      for (int i = 0; i < NCH; i++) q[i].delete();
    end else begin
      for (int i = 0; i < NCH; i++)
        if (ev[i] && out_ready[i]) void'(q[i].pop_front());
      if (in_valid && er) q[in_sel].push_back(in_data);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    rst5 = 1'b1; in_data5 = '0; in_sel5 = '0; in_valid5 = 1'b0; out_ready5 = '0;
    @(negedge clk);

    // Reset state
    step("rst0");
    step("rst1");
    check("rst.out_data", out_data, 64'h0);
`ifdef DEMUX_ROUTER_ERRCNT_EN
    check("rst.err_cnt", err_cnt, 64'h0);
`endif
    rst = 1'b0; rst5 = 1'b0;

    // Single word to channel 2 with every consumer stalled
    in_data = 8'hA5; in_sel = 2'd2; in_valid = 1'b1;
    step("a5.send");
    in_valid = 1'b0; in_data = '0;
    #1;
    check("a5.out_valid", out_valid, 4'b0100);
    check("a5.slice2", out_data[2*WIDTH +: WIDTH], 8'hA5);
    check("a5.ready_sel2", in_ready, 1'b0);
    in_sel = 2'd0;
    #1;
    check("a5.ready_sel0", in_ready, 1'b1);
    out_ready = 4'b0100;
    step("a5.drain");
    out_ready = '0;

    // Back-to-back stream to channel 1 at one word per cycle
    out_ready = 4'b0010; in_sel = 2'd1; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = WIDTH'(k);
      #1;
      check("stream.ready", in_ready, 1'b1);
      if (k > 1) check("stream.slice1", out_data[1*WIDTH +: WIDTH], 64'(k - 1));
      step("stream");
    end
    in_valid = 1'b0;
    #1;
    check("stream.last", out_data[1*WIDTH +: WIDTH], 8'h08);
    step("stream.tail");
    out_ready = '0;

    // Stalled channel 3 holds its sender while channel 0 stays untouched
    in_sel = 2'd3; in_data = 8'h33; in_valid = 1'b1;
    step("c3.fill");
    in_data = 8'h34;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("c3.stall_ready", in_ready, 1'b0);
      check("c3.ch0_idle", out_valid[0], 1'b0);
      step("c3.stall");
    end
    out_ready = 4'b1000;
    #1;
    check("c3.release_ready", in_ready, 1'b1);
    step("c3.release");
    out_ready = '0; in_sel = 2'd0; in_data = 8'h40;
    step("c3.ch0_send");
    in_valid = 1'b0;
    #1;
    check("c3.out_valid", out_valid, 4'b1001);
    check("c3.slice3", out_data[3*WIDTH +: WIDTH], 8'h34);
    check("c3.slice0", out_data[0 +: WIDTH], 8'h40);

    // Fill all slots, then reset discards them
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
    step("full.c1");
    in_sel = 2'd2; in_data = 8'h22;
    step("full.c2");
    in_valid = 1'b0;
    #1;
    check("full.out_valid", out_valid, 4'b1111);
    rst = 1'b1;
    step("full.rst");
    rst = 1'b0;
    #1;
    check("postrst.out_valid", out_valid, 4'b0000);
    check("postrst.out_data", out_data, 64'h0);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h5A;
    step("postrst.send");
    in_valid = 1'b0;
    #1;
    check("postrst.deliver_valid", out_valid, 4'b0100);
    check("postrst.deliver_data", out_data[2*WIDTH +: WIDTH], 8'h5A);
    out_ready = '1;
    step("postrst.drain");

    // Random traffic against the per-channel queues
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, NCH - 1));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      step("rand");
    end
    in_valid = 1'b0; out_ready = '1;
    step("rand.flush");
    #1;
    check("rand.empty", out_valid, 4'b0000);
`ifdef DEMUX_ROUTER_ERRCNT_EN
    check("main.err_cnt", err_cnt, 64'h0);
`endif

    // NCH=5: highest legal channel is delivered, out-of-range selects are dropped
    in_sel5 = 3'd4; in_data5 = 8'h77; in_valid5 = 1'b1;
    #1;
    check("n5.ready_ch4", in_ready5, 1'b1);
    @(negedge clk);
    in_valid5 = 1'b0;
    #1;
    check("n5.valid_ch4", out_valid5, 5'b10000);
    check("n5.slice4", out_data5[4*WIDTH +: WIDTH], 8'h77);
    out_ready5 = '1;
    @(negedge clk);
    in_valid5 = 1'b1; in_sel5 = 3'd5; in_data5 = 8'hEE;
    #1;
    check("n5.ready_sel5", in_ready5, 1'b1);
    @(negedge clk);
    in_sel5 = 3'd6;
    for (int k = 1; k < 300; k++) begin
      #1;
      check("n5.ready_sel6", in_ready5, 1'b1);
      check("n5.no_valid", out_valid5, 5'b00000);
`ifdef DEMUX_ROUTER_ERRCNT_EN
      if (k == 10) check("n5.err_cnt10", err_cnt5, 64'd10);
      if (k == 255) check("n5.err_cnt255", err_cnt5, 64'd255);
`endif
      @(negedge clk);
    end
    in_valid5 = 1'b0;
    #1;
    check("n5.final_valid", out_valid5, 5'b00000);
`ifdef DEMUX_ROUTER_ERRCNT_EN
    check("n5.err_cnt_sat", err_cnt5, 64'd255);
    rst5 = 1'b1;
    @(negedge clk);
    rst5 = 1'b0;
    #1;
    check("n5.err_cnt_rst", err_cnt5, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and sets the data word width in bits (minimum 1).
REQ-002 The parameter NCH SHALL default to 4 and sets the output channel count (minimum 2, not required to be a power of 2).
REQ-003 The derived constant SEL_W SHALL equal $clog2(NCH) and is not user-overridable.
REQ-004 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-006 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-007 Port in_data SHALL be: input, WIDTH bits, input word.
REQ-008 Port in_sel SHALL be: input, SEL_W bits, destination channel index.
REQ-009 Port in_valid SHALL be: input, 1 bit, in_data/in_sel valid.
REQ-010 Port in_ready SHALL be: output, 1 bit, word accepted this cycle when in_valid is also high.
REQ-011 Port out_data SHALL be: output, NCH*WIDTH bits, channel i in bits [i*WIDTH +: WIDTH].
REQ-012 Port out_valid SHALL be: output, NCH bits, per-channel valid.
REQ-013 Port out_ready SHALL be: input, NCH bits, per-channel consumer ready.
REQ-014 Port err_cnt SHALL be: output, 8 bits, out-of-range-select counter (present only with DEMUX_ROUTER_ERRCNT_EN).

Function
REQ-015 Each channel SHALL own a one-entry slot (full flag plus WIDTH-bit register); out_valid[i] equals full[i], and out_data slice i equals the slot register.
REQ-016 An input transfer SHALL occur when in_valid && in_ready; the word is visible on channel in_sel at the next rising edge (latency 1 cycle).
REQ-017 in_ready SHALL be: 0 while rst is high; otherwise 1 if in_sel >= NCH; otherwise (!full[in_sel] || out_ready[in_sel]).
REQ-018 in_ready SHALL depend only on rst, in_sel, full and out_ready, and never on in_data or in_valid.
REQ-019 An output transfer on channel i SHALL occur when out_valid[i] && out_ready[i] and clears full[i], unless the same cycle carries a refill.
REQ-020 A simultaneous pop and refill of the same channel SHALL leave full[i]=1 holding the new word, giving 1 word/cycle sustained throughput per channel.
REQ-021 An input word with in_sel >= NCH SHALL be accepted and discarded, and SHALL NOT modify any slot.
REQ-022 A full, non-ready channel SHALL stall only words addressed to it; other channels keep draining independently.
REQ-023 Word order SHALL be preserved per channel; no word is duplicated or lost except per REQ-021 and REQ-025.
REQ-024 out_data slice i SHALL hold its last value when full[i]=0 (value don't-care to consumers).

Reset
REQ-025 While rst is high at a rising edge, all full flags, slot registers and err_cnt SHALL clear to 0; words buffered mid-operation are discarded.
REQ-026 During reset, out_valid SHALL be 0 and out_data SHALL be 0 from the first post-reset edge; no transfer is accepted in a reset cycle.

Configuration
REQ-027 With macro DEMUX_ROUTER_ERRCNT_EN defined, port err_cnt SHALL exist and increment by 1, saturating at 255, on each transfer discarded per REQ-021.
REQ-028 Without DEMUX_ROUTER_ERRCNT_EN, port err_cnt and its logic SHALL be absent, and discard behaviour is otherwise identical.

Structure
REQ-029 Package demux_pkg SHALL hold the default WIDTH/NCH constants and the saturating-counter maximum (ERR_CNT_MAX=255).
REQ-030 Sub-module demux_slot (one-entry buffer: load, pop, full, data) SHALL be instantiated NCH times via generate.

Verification (NCH=4, WIDTH=8)
REQ-031 Scenario: reset, then in_data=8'hA5, in_sel=2, in_valid=1 for 1 cycle, all out_ready=0 -> next cycle out_valid=4'b0100 and slice 2=8'hA5; in_ready=0 for in_sel=2, 1 for in_sel=0.
REQ-032 Scenario: out_ready[1]=1, stream 8'h01..8'h08 to in_sel=1 on consecutive cycles -> in_ready stays 1 and channel 1 emits 01..08 in order, one per cycle, after 1-cycle latency.
REQ-033 Scenario: channel 3 full with out_ready[3]=0, then send to 3 followed by a send to 0 -> in_ready=0 holds the input until out_ready[3]=1; channel 0 is unaffected meanwhile.
REQ-034 Scenario (NCH=5 build, SEL_W=3): in_sel=6, in_valid=1 for 300 cycles -> in_ready=1, no out_valid rises, and err_cnt reaches 255 and holds (with DEMUX_ROUTER_ERRCNT_EN).
REQ-035 Scenario: all four slots full, assert rst for 1 cycle -> out_valid=0 and all out_data slices=0 next cycle; a send after reset is delivered normally.
REQ-036 Scenario: random in_sel/out_ready for 10k cycles against a per-channel scoreboard queue -> no loss, duplication or reordering.
